// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: controller state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell; purely combinational datapath bit.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add of two WIDTH-bit operands through one full_adder cell, LSB first.
// Optional subtract mode (sum = a - b, cout = no-borrow) under SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             fa_s;
    logic             fa_cout;

    // Subtraction is a + ~b + 1, so only the loaded B operand and initial carry change.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    full_adder u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .s_o    (fa_s),
        .cout_o (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b_load;
                    carry_d  = c_load;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                // Counter parks at the last index instead of wrapping.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); exercises subtract when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_r;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_pass;
    int n_total;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vcin;
        logic             vsub;
        logic [WIDTH-1:0] es;
        logic             ec;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    // Reference: plain integer arithmetic; {cout, sum} is the (WIDTH+1)-bit total.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
        logic [WIDTH-1:0] ny;
        ny = ~y;
        if (s) return {1'b0, x} + {1'b0, ny} + (WIDTH+1)'(1);
        return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
    endfunction

    // One full transaction; counts cycles after the accepting edge (cycle 1 = just after it).
    task automatic run_add(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input logic tc, input logic ts, input logic [WIDTH-1:0] es, input logic ec);
        int busy_cnt;
        int done_at;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub_r = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub_r = 1'($urandom);
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= WIDTH + 4 && done_at == 0; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_at = k;
        end
        chk({nm, " busy_cycles"}, busy_cnt, WIDTH);
        chk({nm, " done_cycle"}, done_at, WIDTH + 1);
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             tbl[$];
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        int               pulses;
        int               first_at;
        int               last_at;
        int               spacing_bad;
        int               sum_bad;

        n_pass  = 0;
        n_total = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_r = 1'b0;

        tbl.push_back('{"add_3c_5a",  8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0});
        tbl.push_back('{"add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{"add_ff_ff_c",8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{"add_00_00_c",8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        tbl.push_back('{"sub_10_01",  8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
        tbl.push_back('{"sub_01_02",  8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0});
        tbl.push_back('{"sub_equal",  8'h5A, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset sum",  32'(sum),  0);
        chk("reset cout", 32'(cout), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle no start busy", 32'(busy), 0);

        for (int i = 0; i < tbl.size(); i++)
            run_add(tbl[i].nm, tbl[i].va, tbl[i].vb, tbl[i].vcin, tbl[i].vsub, tbl[i].es, tbl[i].ec);

        // Second start pulse mid-SHIFT must be ignored.
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; sub_r = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3 * WIDTH; k++) begin
            if (done) begin
                pulses++;
                chk("midstart sum",  32'(sum),  32'h02);
                chk("midstart cout", 32'(cout), 0);
            end
            @(negedge clk);
        end
        chk("midstart done_pulses", pulses, 1);

        // Asynchronous reset during SHIFT clears everything at once.
        @(negedge clk);
        a = 8'h55; b = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst busy", 32'(busy), 1);
        chk("pre_rst sum_held", 32'(sum), 32'h02);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst sum",  32'(sum),  0);
        chk("midrst cout", 32'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        run_add("post_rst", 8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0);

        // Start held high: back-to-back adds, one result every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; sub_r = 1'b0; start = 1'b1;
        pulses = 0; first_at = -1; last_at = -1; spacing_bad = 0; sum_bad = 0;
        for (int k = 0; k < 4 * (WIDTH + 2) + 2; k++) begin
            @(negedge clk);
            if (done) begin
                if (last_at >= 0 && k - last_at != WIDTH + 2) spacing_bad++;
                if (first_at < 0) first_at = k;
                if (sum !== 8'h30) sum_bad++;
                last_at = k;
                pulses++;
            end
        end
        start = 1'b0;
        chk("b2b pulses", pulses, 4);
        chk("b2b spacing_errors", spacing_bad, 0);
        chk("b2b sum_errors", sum_bad, 0);
        chk("b2b first_done", first_at, WIDTH);
        repeat (WIDTH + 3) @(negedge clk);
        chk("b2b idle busy", 32'(busy), 0);

        // Randomized against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (i == 0) begin ra = '1; rb = '1; end
            r = ref_add(ra, rb, rc, rs);
            run_add($sformatf("rand%0d", i), ra, rb, rc, rs, r[WIDTH-1:0], r[WIDTH]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
